// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU-sharing arbiter: ALU opcode, data word and arbiter FSM state.
package alu_share_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping modulo N.
module alu_share_arbiter_rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] cand;

  // Scan last+1 .. last+N so 'last' itself has lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDW'((32'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// Operands are registered toward the ALU; results are registered and returned with a 1-cycle ack.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*4-1:0] req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   ack,
  output logic [31:0]       rsp_out,
  output logic              rsp_neg,
  output logic              rsp_ovf,
  output logic              rsp_zero,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic [3:0]        alu_aluop,
  output logic [31:0]       alu_porta,
  output logic [31:0]       alu_portb,
  input  logic [31:0]       alu_out_port,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero
);

  arb_state_t     state_q, state_d;
  logic [3:0]     op_q, op_d;
  word_t          a_q, a_d, b_q, b_d;
  logic [IDW-1:0] grant_q, grant_d, last_q, last_d;
  word_t          out_q, out_d;
  logic           neg_q, neg_d, ovf_q, ovf_d, zero_q, zero_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;

  alu_share_arbiter_rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req  (req),
    .last (last_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      grant_q <= '0;
      last_q  <= IDW'(NREQ - 1);
      out_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      out_q   <= out_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    grant_d = grant_q;
    last_d  = last_q;
    out_d   = out_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_ISSUE;
          op_d    = req_op[32'(pick_idx)*4 +: 4];
          a_d     = req_a[32'(pick_idx)*32 +: 32];
          b_d     = req_b[32'(pick_idx)*32 +: 32];
          grant_d = pick_idx;
          last_d  = pick_idx;
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_RESP;
        out_d   = alu_out_port;
        neg_d   = alu_negative;
        ovf_d   = alu_overflow;
        zero_d  = alu_zero;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == ARB_RESP) begin
      ack[grant_q] = 1'b1;
    end
  end

  // Operand registers only change on the IDLE grant edge, so the ALU inputs are quiet otherwise.
  assign alu_aluop = op_q;
  assign alu_porta = a_q;
  assign alu_portb = b_q;

  assign rsp_out  = out_q;
  assign rsp_neg  = neg_q;
  assign rsp_ovf  = ovf_q;
  assign rsp_zero = zero_q;
  assign busy     = (state_q != ARB_IDLE);
  assign grant_id = grant_q;

endmodule
